// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer for a Y86-64 SEQ core: fetch/memory handshakes, stage strobes, PC and status.
// Optional Y86_SEQ_PERF_EN adds retired-instruction and stall counters.
module y86_seq_ctrl #(
    parameter int unsigned       ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              f_req,
    input  logic              f_ack,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic              f_err,
    input  logic              cnd,
    output logic              m_req,
    output logic              m_we,
    input  logic              m_ack,
    input  logic              m_err,
    input  logic [ADDR_W-1:0] valM,
    output logic              dec_en,
    output logic              exe_en,
    output logic              wb_en,
    output logic              wbm_en,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        stat,
    output logic              retired
`ifdef Y86_SEQ_PERF_EN
    ,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StDecode  = 3'd2;
    localparam logic [2:0] StExecute = 3'd3;
    localparam logic [2:0] StMemory  = 3'd4;
    localparam logic [2:0] StWrback  = 3'd5;
    localparam logic [2:0] StPcupd   = 3'd6;
    localparam logic [2:0] StHalted  = 3'd7;

    localparam logic [1:0] StatAok = 2'd0;
    localparam logic [1:0] StatHlt = 2'd1;
    localparam logic [1:0] StatAdr = 2'd2;
    localparam logic [1:0] StatIns = 2'd3;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_stat;
    logic [3:0]        r_icode;
    logic [ADDR_W-1:0] r_valc;
    logic [ADDR_W-1:0] r_valp;
    logic [ADDR_W-1:0] r_valm;
    logic              r_cnd;
    logic [31:0]       r_wait;

    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [1:0]        w_stat_nxt;
    logic [31:0]       w_wait_nxt;
    logic              w_cap_f;
    logic              w_cap_m;
    logic              w_cap_c;
    logic              w_illegal;
    logic              w_mem_instr;
    logic              w_timeout;

    assign w_illegal = (f_icode > 4'hB)
                     || ((f_icode == 4'h2) && (f_ifun > 4'h6))
                     || ((f_icode == 4'h7) && (f_ifun > 4'h6))
                     || ((f_icode == 4'h6) && (f_ifun > 4'h3));

    assign w_mem_instr = r_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    // Counter holds completed no-ack cycles, so this flags the MEM_TIMEOUT-th one.
    assign w_timeout = ((r_wait + 32'd1) == MEM_TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stat_nxt  = r_stat;
        w_wait_nxt  = '0;
        w_cap_f     = 1'b0;
        w_cap_m     = 1'b0;
        w_cap_c     = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StFetch;
                end
            end
            StFetch: begin
                if (f_ack) begin
                    if (f_err) begin
                        w_stat_nxt  = StatAdr;
                        w_state_nxt = StHalted;
                    end else if (w_illegal) begin
                        w_stat_nxt  = StatIns;
                        w_state_nxt = StHalted;
                    end else if (f_icode == 4'h0) begin
                        w_stat_nxt  = StatHlt;
                        w_pc_nxt    = f_valP;
                        w_state_nxt = StHalted;
                    end else begin
                        w_cap_f     = 1'b1;
                        w_state_nxt = StDecode;
                    end
                end else if (w_timeout) begin
                    w_stat_nxt  = StatAdr;
                    w_state_nxt = StHalted;
                end else begin
                    w_wait_nxt = r_wait + 32'd1;
                end
            end
            StDecode: begin
                w_state_nxt = StExecute;
            end
            StExecute: begin
                w_cap_c     = 1'b1;
                w_state_nxt = w_mem_instr ? StMemory : StWrback;
            end
            StMemory: begin
                if (m_ack) begin
                    if (m_err) begin
                        w_stat_nxt  = StatAdr;
                        w_state_nxt = StHalted;
                    end else begin
                        w_cap_m     = 1'b1;
                        w_state_nxt = StWrback;
                    end
                end else if (w_timeout) begin
                    w_stat_nxt  = StatAdr;
                    w_state_nxt = StHalted;
                end else begin
                    w_wait_nxt = r_wait + 32'd1;
                end
            end
            StWrback: begin
                w_state_nxt = StPcupd;
            end
            StPcupd: begin
                if ((r_icode == 4'h8) || ((r_icode == 4'h7) && r_cnd)) begin
                    w_pc_nxt = r_valc;
                end else if (r_icode == 4'h9) begin
                    w_pc_nxt = r_valm;
                end else begin
                    w_pc_nxt = r_valp;
                end
                w_state_nxt = StFetch;
            end
            StHalted: begin
                w_state_nxt = StHalted;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
            r_stat  <= StatAok;
            r_icode <= 4'h0;
            r_valc  <= '0;
            r_valp  <= '0;
            r_valm  <= '0;
            r_cnd   <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_stat  <= w_stat_nxt;
            r_wait  <= w_wait_nxt;
            if (w_cap_f) begin
                r_icode <= f_icode;
                r_valc  <= f_valC;
                r_valp  <= f_valP;
            end
            if (w_cap_m) begin
                r_valm <= valM;
            end
            if (w_cap_c) begin
                r_cnd <= cnd;
            end
        end
    end

    // Strobes decode straight from state so reset clears them without waiting for a clock.
    assign f_req   = (r_state == StFetch);
    assign m_req   = (r_state == StMemory);
    assign m_we    = m_req && (r_icode inside {4'h4, 4'h8, 4'hA});
    assign dec_en  = (r_state == StDecode);
    assign exe_en  = (r_state == StExecute);
    assign wb_en   = (r_state == StWrback)
                   && ((r_icode inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB})
                       || ((r_icode == 4'h2) && r_cnd));
    assign wbm_en  = (r_state == StWrback) && (r_icode inside {4'h5, 4'hB});
    assign retired = (r_state == StPcupd);
    assign pc      = r_pc;
    assign stat    = r_stat;

`ifdef Y86_SEQ_PERF_EN
    logic [31:0] r_instr_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == StFetch) && !f_ack) || ((r_state == StMemory) && !m_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (retired) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign instr_cnt = r_instr_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Self-checking bench for y86_seq_ctrl: instruction vector table with a scoreboard plus
// hand-written sequences for timeout, halt/illegal, async reset and stray acks.
module tb_y86_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        f_req;
    logic        f_ack;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        f_err;
    logic        cnd;
    logic        m_req;
    logic        m_we;
    logic        m_ack;
    logic        m_err;
    logic [63:0] valM;
    logic        dec_en;
    logic        exe_en;
    logic        wb_en;
    logic        wbm_en;
    logic [63:0] pc;
    logic [1:0]  stat;
    logic        retired;
`ifdef Y86_SEQ_PERF_EN
    logic [31:0] instr_cnt;
    logic [31:0] stall_cnt;
`endif

    y86_seq_ctrl #(
        .ADDR_W      (64),
        .RESET_PC    (64'h0),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .f_req     (f_req),
        .f_ack     (f_ack),
        .f_icode   (f_icode),
        .f_ifun    (f_ifun),
        .f_valC    (f_valC),
        .f_valP    (f_valP),
        .f_err     (f_err),
        .cnd       (cnd),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .valM      (valM),
        .dec_en    (dec_en),
        .exe_en    (exe_en),
        .wb_en     (wb_en),
        .wbm_en    (wbm_en),
        .pc        (pc),
        .stat      (stat),
        .retired   (retired)
`ifdef Y86_SEQ_PERF_EN
        ,
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] valm;
        logic        cnd;
        logic [63:0] exp_pc;
        logic        exp_mem;
        logic        exp_mwe;
        logic [3:0]  exp_wb;
        logic [3:0]  exp_wbm;
    } vec_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        mem;
        logic        mwe;
        logic [3:0]  wb;
        logic [3:0]  wbm;
        logic [3:0]  dec;
        logic [3:0]  exe;
        logic [3:0]  lat;
    } exp_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void setv(input int i, input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [63:0] vc, input logic [63:0] vp,
                                 input logic [63:0] vm, input logic c, input logic [63:0] epc,
                                 input logic emem, input logic emwe, input logic [3:0] ewb,
                                 input logic [3:0] ewbm);
        vecs[i] = '{icode: ic, ifun: fn, valc: vc, valp: vp, valm: vm, cnd: c, exp_pc: epc,
                    exp_mem: emem, exp_mwe: emwe, exp_wb: ewb, exp_wbm: ewbm};
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; f_ack = 1'b0; f_err = 1'b0; m_ack = 1'b0; m_err = 1'b0; cnd = 1'b0;
        f_icode = 4'h0; f_ifun = 4'h0; f_valC = '0; f_valP = '0; valM = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_dut();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one fetch response in the current (FETCH) cycle and moves to the next negedge.
    task automatic fetch_ack(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                             input logic [63:0] vp, input logic err);
        f_ack = 1'b1; f_err = err; f_icode = ic; f_ifun = fn; f_valC = vc; f_valP = vp;
        @(negedge clk);
        f_ack = 1'b0; f_err = 1'b0;
    endtask

    task automatic wait_mreq(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (m_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, seen, 1'b1);
    endtask

    task automatic run_instr(input vec_t v);
        exp_t e;
        exp_t got;
        bit   exe_seen = 1'b0;
        e = '{pc: v.exp_pc, mem: v.exp_mem, mwe: v.exp_mwe, wb: v.exp_wb, wbm: v.exp_wbm,
              dec: 4'd1, exe: 4'd1, lat: v.exp_mem ? 4'd6 : 4'd5};
        sb.push_back(e);
        got = '0;
        check("fetch_req", f_req, 1'b1);
        cnd = v.cnd;
        f_ack = 1'b1; f_err = 1'b0; f_icode = v.icode; f_ifun = v.ifun;
        f_valC = v.valc; f_valP = v.valp;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            f_ack = 1'b0; m_ack = 1'b0;
            // Flip cnd after EXECUTE so only a properly latched value gives the right result.
            if (exe_seen) cnd = ~v.cnd;
            if (exe_en) exe_seen = 1'b1;
            if (dec_en) got.dec = got.dec + 4'd1;
            if (exe_en) got.exe = got.exe + 4'd1;
            if (wb_en) got.wb = got.wb + 4'd1;
            if (wbm_en) got.wbm = got.wbm + 4'd1;
            if (m_req) begin
                got.mem = 1'b1; got.mwe = m_we;
                m_ack = 1'b1; m_err = 1'b0; valM = v.valm;
            end
            if (retired) begin
                got.lat = 4'(k);
                break;
            end
        end
        @(negedge clk);
        got.pc = pc;
        if (sb.size() == 0) begin
            check("sb_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            check("latency", got.lat, e.lat);
            check("pc", got.pc, e.pc);
            check("mem_access", got.mem, e.mem);
            check("m_we", got.mwe, e.mwe);
            check("wb_en_count", got.wb, e.wb);
            check("wbm_en_count", got.wbm, e.wbm);
            check("dec_en_count", got.dec, e.dec);
            check("exe_en_count", got.exe, e.exe);
            check("stat_aok", stat, 2'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ill [5];
        int         mcnt;

        //    i  ic    fn    valC                  valP     valM    cnd  exp_pc            mem  mwe  wb wbm
        setv(0,  4'h3, 4'h0, 64'h1234,             64'h0A,  64'h0,  0, 64'h0A,            0, 0, 1, 0);
        setv(1,  4'h8, 4'h0, 64'h100,              64'h20,  64'h0,  0, 64'h100,           1, 1, 1, 0);
        setv(2,  4'h9, 4'h0, 64'h0,                64'h101, 64'h20, 1, 64'h20,            1, 0, 1, 0);
        setv(3,  4'h7, 4'h4, 64'h400,              64'h29,  64'h0,  0, 64'h29,            0, 0, 0, 0);
        setv(4,  4'h7, 4'h4, 64'h400,              64'h32,  64'h0,  1, 64'h400,           0, 0, 0, 0);
        setv(5,  4'h2, 4'h1, 64'h0,                64'h402, 64'h0,  0, 64'h402,           0, 0, 0, 0);
        setv(6,  4'h2, 4'h1, 64'h0,                64'h404, 64'h0,  1, 64'h404,           0, 0, 1, 0);
        setv(7,  4'h5, 4'h0, 64'h8,                64'h40E, 64'hDEAD, 0, 64'h40E,         1, 0, 0, 1);
        setv(8,  4'h4, 4'h0, 64'h8,                64'h418, 64'h0,  0, 64'h418,           1, 1, 0, 0);
        setv(9,  4'hB, 4'h0, 64'h0,                64'h41A, 64'h55, 0, 64'h41A,           1, 0, 1, 1);
        setv(10, 4'hA, 4'h0, 64'h0,                64'h41C, 64'h0,  0, 64'h41C,           1, 1, 1, 0);
        setv(11, 4'h6, 4'h3, 64'h0,                64'h41E, 64'h0,  0, 64'h41E,           0, 0, 1, 0);
        setv(12, 4'h1, 4'h0, 64'h0,                64'h41F, 64'h0,  0, 64'h41F,           0, 0, 0, 0);
        setv(13, 4'h7, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h428, 64'h0, 1,
             64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        setv(14, 4'h3, 4'h0, 64'h7,                64'h9,   64'h0,  0, 64'h9,             0, 0, 1, 0);

        // Reset state, then stray acks and no start in IDLE.
        reset_dut();
        check("rst_pc", pc, 64'h0);
        check("rst_stat", stat, 2'd0);
        check("rst_f_req", f_req, 1'b0);
        check("rst_m_req", m_req, 1'b0);
        check("rst_retired", retired, 1'b0);
        f_ack = 1'b1; m_ack = 1'b1;
        repeat (2) @(negedge clk);
        f_ack = 1'b0; m_ack = 1'b0;
        check("idle_holds_f_req", f_req, 1'b0);
        check("idle_holds_dec_en", dec_en, 1'b0);
        start_dut();

        for (int i = 0; i < NVEC; i++) run_instr(vecs[i]);

        // rmmovq whose memory ack never arrives.
        fetch_ack(4'h4, 4'h0, 64'h8, 64'h50, 1'b0);
        mcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_req) mcnt++;
            else if (mcnt > 0) break;
        end
        check("timeout_mreq_cycles", mcnt, 15);
        check("timeout_stat", stat, 2'd2);
        check("timeout_m_req", m_req, 1'b0);
        check("timeout_f_req", f_req, 1'b0);
        check("timeout_pc", pc, 64'h9);
`ifdef Y86_SEQ_PERF_EN
        check("perf_stall_cnt", stall_cnt, 32'd15);
        check("perf_instr_cnt", instr_cnt, 32'(NVEC));
`endif
        start_dut();
        repeat (3) @(negedge clk);
        check("halted_f_req", f_req, 1'b0);
        check("halted_stat", stat, 2'd2);
        check("halted_pc", pc, 64'h9);

        // halt instruction: pc advances, start ignored afterwards.
        reset_dut();
        start_dut();
        fetch_ack(4'h0, 4'h0, 64'h0, 64'h55, 1'b0);
        check("hlt_stat", stat, 2'd1);
        check("hlt_pc", pc, 64'h55);
        check("hlt_retired", retired, 1'b0);
        start_dut();
        repeat (3) @(negedge clk);
        check("hlt_start_ignored", f_req, 1'b0);
        check("hlt_stat_frozen", stat, 2'd1);
        check("hlt_pc_frozen", pc, 64'h55);

        // Illegal encodings.
        ill[0] = 8'hC0; ill[1] = 8'h27; ill[2] = 8'h77; ill[3] = 8'h64; ill[4] = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            reset_dut();
            start_dut();
            fetch_ack(ill[i][7:4], ill[i][3:0], 64'h40, 64'h60, 1'b0);
            check("ins_stat", stat, 2'd3);
            check("ins_pc", pc, 64'h0);
            check("ins_dec_en", dec_en, 1'b0);
        end

        // Fetch error.
        reset_dut();
        start_dut();
        fetch_ack(4'h3, 4'h0, 64'h40, 64'h60, 1'b1);
        check("ferr_stat", stat, 2'd2);
        check("ferr_pc", pc, 64'h0);
        check("ferr_f_req", f_req, 1'b0);

        // Stray m_ack during FETCH, then async reset in the middle of a memory handshake.
        reset_dut();
        start_dut();
        m_ack = 1'b1;
        repeat (3) @(negedge clk);
        m_ack = 1'b0;
        check("fetch_ignores_m_ack", f_req, 1'b1);
        check("fetch_no_dec_en", dec_en, 1'b0);
        run_instr('{icode: 4'h3, ifun: 4'h0, valc: 64'h0, valp: 64'h30, valm: 64'h0, cnd: 1'b0,
                    exp_pc: 64'h30, exp_mem: 1'b0, exp_mwe: 1'b0, exp_wb: 4'd1, exp_wbm: 4'd0});
        fetch_ack(4'h8, 4'h0, 64'h100, 64'h3A, 1'b0);
        wait_mreq("reach_memory");
        check("mem_m_we", m_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_m_req", m_req, 1'b0);
        check("async_rst_pc", pc, 64'h0);
        check("async_rst_stat", stat, 2'd0);
`ifdef Y86_SEQ_PERF_EN
        check("async_rst_instr_cnt", instr_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", f_req, 1'b0);

        // Memory error on ret.
        start_dut();
        fetch_ack(4'h9, 4'h0, 64'h0, 64'h70, 1'b0);
        wait_mreq("reach_memory_merr");
        m_ack = 1'b1; m_err = 1'b1;
        @(negedge clk);
        m_ack = 1'b0; m_err = 1'b0;
        check("merr_stat", stat, 2'd2);
        check("merr_m_req", m_req, 1'b0);
        check("merr_pc", pc, 64'h0);

        check("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
